// File: rtl/sram_mem_ctrl_pkg.sv
// Shared types and default widths for the SRAM memory controller and the I/D arbiter above it.
`ifndef SRAM_MEM_CTRL_PKG_SV
`define SRAM_MEM_CTRL_PKG_SV
package sram_mem_ctrl_pkg;

    localparam int MEM_ADDR_W = 32;
    localparam int MEM_DATA_W = 32;

    typedef enum logic [1:0] {
        MEM_ST_IDLE   = 2'd0,
        MEM_ST_WAIT   = 2'd1,
        MEM_ST_ACCESS = 2'd2,
        MEM_ST_RESP   = 2'd3
    } mem_state_t;

endpackage
`endif

// File: rtl/sram_mem_ctrl_if.sv
// Arbiter-to-memory request/response bundle.
interface sram_mem_ctrl_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // Handshake: the master pulses memReq with memAddr/memWr/memDataIn valid in the same cycle.
    // The slave accepts only while memBusyOut=0, raises memBusyOut on the accepting edge, and
    // holds memDataOut/memErr stable from busy fall until the next accepted request.
    logic [ADDR_W-1:0] memAddr;
    logic              memWr;
    logic              memReq;
    logic [DATA_W-1:0] memDataIn;
    logic [DATA_W-1:0] memDataOut;
    logic              memBusyOut;
    logic              memErr;

    modport master (
        output memAddr, memWr, memReq, memDataIn,
        input  memDataOut, memBusyOut, memErr
    );

    modport slave (
        input  memAddr, memWr, memReq, memDataIn,
        output memDataOut, memBusyOut, memErr
    );
endinterface

// File: rtl/sram_mem_ctrl_array.sv
// Single-port word RAM: synchronous read, write-first (rdata shows the written word).
module sram_array #(
    parameter int DATA_W     = 32,
    parameter int DEPTH_LOG2 = 12
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic                  en,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic [DATA_W-1:0]     wdata,
    output logic [DATA_W-1:0]     rdata
);
    logic [DATA_W-1:0] mem [0:(1<<DEPTH_LOG2)-1];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
                rdata     <= wdata;
            end else begin
                rdata <= mem[addr];
            end
        end
    end
endmodule

// File: rtl/sram_mem_ctrl.sv
// Memory-side slave: serialises one access at a time with programmable wait states,
// and reports misaligned or out-of-range addresses instead of touching the array.
module sram_mem_ctrl
    import sram_mem_ctrl_pkg::*;
#(
    parameter int                 ADDR_W      = MEM_ADDR_W,
    parameter int                 DATA_W      = MEM_DATA_W,
    parameter int                 DEPTH_LOG2  = 12,
    parameter logic [ADDR_W-1:0]  BASE_ADDR   = '0,
    parameter int                 WAIT_CYCLES = 2
) (
    input  logic            clk,
    input  logic            reset,
    sram_mem_ctrl_if.slave  mem,
    output mem_state_t      dbg_state
);
    localparam mem_state_t FIRST_ST = (WAIT_CYCLES > 0) ? MEM_ST_WAIT : MEM_ST_ACCESS;

    mem_state_t        state, nxt_state;
    logic [3:0]        cnt;
    logic [ADDR_W-1:0] addr_q;
    logic              wr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              err_q;
    logic              busy_q;
    logic              merr_q;
    logic [DATA_W-1:0] dout_q;

    logic [ADDR_W-1:0]     diff;
    logic                  acc_err;
    logic [DEPTH_LOG2-1:0] arr_idx;
    logic                  arr_en, arr_we;
    logic [DATA_W-1:0]     arr_rdata;

    // The addr<BASE check stops the unsigned subtraction from wrapping into range.
    assign diff    = addr_q - BASE_ADDR;
    assign acc_err = (addr_q[1:0] != 2'b00) || (addr_q < BASE_ADDR) ||
                     ((diff >> (DEPTH_LOG2 + 2)) != '0);
    assign arr_idx = diff[DEPTH_LOG2+1:2];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= MEM_ST_IDLE;
        else        state <= nxt_state;
    end

    always_comb begin
        nxt_state = state;
        arr_en    = 1'b0;
        arr_we    = 1'b0;
        case (state)
            MEM_ST_IDLE:   if (mem.memReq) nxt_state = FIRST_ST;
            MEM_ST_WAIT:   if (cnt == 4'd1) nxt_state = MEM_ST_ACCESS;
            MEM_ST_ACCESS: begin
                arr_en    = !acc_err;
                arr_we    = wr_q && !acc_err;
                nxt_state = MEM_ST_RESP;
            end
            MEM_ST_RESP:   nxt_state = MEM_ST_IDLE;
            default:       nxt_state = MEM_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt     <= '0;
            addr_q  <= '0;
            wr_q    <= 1'b0;
            wdata_q <= '0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            merr_q  <= 1'b0;
            dout_q  <= '0;
        end else begin
            case (state)
                MEM_ST_IDLE: if (mem.memReq) begin
                    addr_q  <= mem.memAddr;
                    wr_q    <= mem.memWr;
                    wdata_q <= mem.memDataIn;
                    busy_q  <= 1'b1;
                    merr_q  <= 1'b0;
                    cnt     <= 4'(WAIT_CYCLES);
                end
                MEM_ST_WAIT:   cnt   <= cnt - 4'd1;
                MEM_ST_ACCESS: err_q <= acc_err;
                MEM_ST_RESP: begin
                    busy_q <= 1'b0;
                    if (err_q) begin
                        dout_q <= '0;
                        merr_q <= 1'b1;
                    end else if (!wr_q) begin
                        dout_q <= arr_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

    sram_array #(
        .DATA_W     (DATA_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_array (
        .clk   (clk),
        .we    (arr_we),
        .en    (arr_en),
        .addr  (arr_idx),
        .wdata (wdata_q),
        .rdata (arr_rdata)
    );

    assign mem.memDataOut = dout_q;
    assign mem.memBusyOut = busy_q;
    assign mem.memErr     = merr_q;
    assign dbg_state      = state;
endmodule

// File: tb/tb_sram_mem_ctrl.sv
// Directed bench for sram_mem_ctrl: one instance with 2 wait states, one with none.
module tb_sram_mem_ctrl;
    import sram_mem_ctrl_pkg::*;

    logic clk;
    logic reset;
    int   vectors;
    int   miscompares;
    int   cyc;

    mem_state_t st_w2, st_w0;

    sram_mem_ctrl_if #(.ADDR_W(32), .DATA_W(32)) if_w2 ();
    sram_mem_ctrl_if #(.ADDR_W(32), .DATA_W(32)) if_w0 ();

    sram_mem_ctrl #(.DEPTH_LOG2(12), .BASE_ADDR(32'h0), .WAIT_CYCLES(2)) dut_w2 (
        .clk       (clk),
        .reset     (reset),
        .mem       (if_w2.slave),
        .dbg_state (st_w2)
    );

    sram_mem_ctrl #(.DEPTH_LOG2(12), .BASE_ADDR(32'h0), .WAIT_CYCLES(0)) dut_w0 (
        .clk       (clk),
        .reset     (reset),
        .mem       (if_w0.slave),
        .dbg_state (st_w0)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int sel, input logic [31:0] a, input logic w,
                         input logic [31:0] d, input logic r);
        if (sel == 0) begin
            if_w2.memAddr = a; if_w2.memWr = w; if_w2.memDataIn = d; if_w2.memReq = r;
        end else begin
            if_w0.memAddr = a; if_w0.memWr = w; if_w0.memDataIn = d; if_w0.memReq = r;
        end
    endtask

    function automatic logic busy_of(input int sel);
        return (sel == 0) ? if_w2.memBusyOut : if_w0.memBusyOut;
    endfunction

    // Issue one request and count busy cycles; pulse_at>0 injects a stray write
    // (addr 0, data 0x77) at that busy cycle, which must be ignored.
    task automatic run_req(input int sel, input logic [31:0] a, input logic w,
                           input logic [31:0] d, input int pulse_at, output int n);
        @(negedge clk);
        drive(sel, a, w, d, 1'b1);
        @(negedge clk);
        drive(sel, a, w, d, 1'b0);
        n = 0;
        while (busy_of(sel) && n < 40) begin
            n++;
            if (n == pulse_at) drive(sel, 32'h0, 1'b1, 32'h77, 1'b1);
            else               drive(sel, a, w, d, 1'b0);
            @(negedge clk);
        end
        drive(sel, a, w, d, 1'b0);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b0;
        drive(0, 32'h0, 1'b0, 32'h0, 1'b0);
        drive(1, 32'h0, 1'b0, 32'h0, 1'b0);
        repeat (3) @(negedge clk);
        check("rst_busy",  32'(if_w2.memBusyOut), 32'h0);
        check("rst_dout",  if_w2.memDataOut,      32'h0);
        check("rst_err",   32'(if_w2.memErr),     32'h0);
        check("rst_state", 32'(st_w2),            32'(MEM_ST_IDLE));
        reset = 1'b1;

        // write then read back with two wait states
        run_req(0, 32'h10, 1'b1, 32'hDEADBEEF, 0, cyc);
        check("wr10_busy", 32'(cyc), 32'd4);
        check("wr10_err",  32'(if_w2.memErr), 32'h0);
        run_req(0, 32'h10, 1'b0, 32'h0, 0, cyc);
        check("rd10_busy", 32'(cyc), 32'd4);
        check("rd10_data", if_w2.memDataOut, 32'hDEADBEEF);
        check("rd10_err",  32'(if_w2.memErr), 32'h0);
        repeat (5) @(negedge clk);
        check("rd10_hold", if_w2.memDataOut, 32'hDEADBEEF);

        // error cases
        run_req(0, 32'h0, 1'b1, 32'hCAFEF00D, 0, cyc);
        check("wr0_busy", 32'(cyc), 32'd4);
        run_req(0, 32'h2, 1'b0, 32'h0, 0, cyc);
        check("mis_busy", 32'(cyc), 32'd4);
        check("mis_data", if_w2.memDataOut, 32'h0);
        check("mis_err",  32'(if_w2.memErr), 32'h1);
        run_req(0, 32'h4000, 1'b1, 32'h99999999, 0, cyc);
        check("oor_busy", 32'(cyc), 32'd4);
        check("oor_err",  32'(if_w2.memErr), 32'h1);
        run_req(0, 32'h0, 1'b0, 32'h0, 0, cyc);
        check("oor_noalias", if_w2.memDataOut, 32'hCAFEF00D);
        check("rd0_errclr",  32'(if_w2.memErr), 32'h0);
        run_req(0, 32'h2, 1'b0, 32'h0, 0, cyc);
        run_req(0, 32'h10, 1'b0, 32'h0, 0, cyc);
        check("rd10b_data",   if_w2.memDataOut, 32'hDEADBEEF);
        check("rd10b_errclr", 32'(if_w2.memErr), 32'h0);

        // stray request while busy
        run_req(0, 32'h10, 1'b0, 32'h0, 2, cyc);
        check("stray_busy", 32'(cyc), 32'd4);
        check("stray_data", if_w2.memDataOut, 32'hDEADBEEF);
        repeat (2) @(negedge clk);
        check("stray_idle", 32'(st_w2), 32'(MEM_ST_IDLE));
        run_req(0, 32'h0, 1'b0, 32'h0, 0, cyc);
        check("stray_nowr", if_w2.memDataOut, 32'hCAFEF00D);

        // reset in the middle of WAIT aborts a pending write
        run_req(0, 32'h44, 1'b1, 32'h11111111, 0, cyc);
        @(negedge clk);
        drive(0, 32'h44, 1'b1, 32'h22222222, 1'b1);
        @(negedge clk);
        drive(0, 32'h44, 1'b1, 32'h22222222, 1'b0);
        check("mid_state", 32'(st_w2), 32'(MEM_ST_WAIT));
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        check("mid_busy",  32'(if_w2.memBusyOut), 32'h0);
        check("mid_dout",  if_w2.memDataOut,      32'h0);
        check("mid_err",   32'(if_w2.memErr),     32'h0);
        check("mid_idle",  32'(st_w2),            32'(MEM_ST_IDLE));
        @(negedge clk);
        reset = 1'b1;
        run_req(0, 32'h44, 1'b0, 32'h0, 0, cyc);
        check("post_busy", 32'(cyc), 32'd4);
        check("post_data", if_w2.memDataOut, 32'h11111111);

        // zero wait states
        run_req(1, 32'h0, 1'b1, 32'h00000013, 0, cyc);
        check("w0_wr_busy", 32'(cyc), 32'd2);
        run_req(1, 32'h0, 1'b0, 32'h0, 0, cyc);
        check("w0_rd_busy", 32'(cyc), 32'd2);
        check("w0_rd_data", if_w0.memDataOut, 32'h00000013);
        check("w0_rd_err",  32'(if_w0.memErr), 32'h0);
        run_req(1, 32'h3, 1'b0, 32'h0, 0, cyc);
        check("w0_mis_busy", 32'(cyc), 32'd2);
        check("w0_mis_err",  32'(if_w0.memErr), 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/sram_mem_ctrl.md
Name: sram_mem_ctrl

Overview:
- Memory-side slave directly downstream of the time-multiplexed I/D arbiter. Consumes the arbiter's memory interface: one-cycle request pulse, address, write flag and write data.
- Returns read data and a busy indication the arbiter polls. Owns a word-addressed single-port SRAM array.
- Inserts a programmable number of wait states so arbiter/core stall paths are exercised, and flags misaligned or out-of-range accesses.

Parameters:
- ADDR_W, 32, width of memAddr (byte address).
- DATA_W, 32, width of data words.
- DEPTH_LOG2, 12, log2 of array depth in words (default 4096 words).
- BASE_ADDR, 0, byte address mapped to word 0.
- WAIT_CYCLES, 2, extra wait states before array access (0..15).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- memAddr  input  ADDR_W  byte address; sampled only when memReq=1 in IDLE.
- memWr  input  1  1 = write, 0 = read; sampled with memAddr.
- memReq  input  1  request pulse (normally one cycle).
- memDataIn  input  DATA_W  write data; sampled with memAddr.
- memDataOut  output  DATA_W  read data; held stable until the next accepted request.
- memBusyOut  output  1  high while a request is in progress.
- memErr  output  1  last access was misaligned or out of range; held like memDataOut.

Behaviour:
- Reset (reset=0, async): state=IDLE, memBusyOut=0, memDataOut=0, memErr=0, wait counter=0. Array contents are not reset. Reset mid-access aborts the access; any write not yet performed is lost.
- States: IDLE, WAIT, ACCESS, RESP (2-bit encoding).
- IDLE: at a clock edge with memReq=1:
  - Latch addr, wr and data.
  - memBusyOut<=1; memErr<=0.
  - Counter<=WAIT_CYCLES.
  - Next state is WAIT if WAIT_CYCLES>0, else ACCESS.
- WAIT: counter decrements each cycle; when counter==1, next state is ACCESS.
- ACCESS: compute index=(addr-BASE_ADDR)>>2.
  - Error if addr[1:0]!=0, addr<BASE_ADDR, or index>=2**DEPTH_LOG2.
  - On error: no array access; error flag is registered.
  - Otherwise: a write stores the latched data; a read issues a synchronous array read (data available next cycle).
  - Next state: RESP.
- RESP:
  - Read: memDataOut<=array rdata.
  - Write: memDataOut unchanged.
  - Error: memDataOut<=0 and memErr<=1.
  - memBusyOut<=0; next state IDLE.
- Latency: memBusyOut is high for exactly WAIT_CYCLES+2 cycles, starting the cycle after the edge that sampled memReq. The next request is accepted at the first edge after busy falls.
- Arbiter compatibility: busy rises on the edge after the arbiter raises memReq, so the arbiter's first busy sample sees 1. memDataOut is valid from busy fall until the next accepted request, which covers the arbiter's one-cycle capture delay.
- memReq while busy (WAIT/ACCESS/RESP): ignored, not queued, and no effect on the in-flight access.
- memReq held high across multiple cycles: re-accepted in IDLE as a new access. The arbiter never does this; it is still well-defined.
- Write followed by read to the same address returns the new data; no bypass is needed because accesses are serialized.
- Address arithmetic uses ADDR_W-bit unsigned subtraction. The addr<BASE_ADDR check prevents wrap-around aliasing.

Decomposition:
- Shared package/header (`ifndef-guarded include) holds:
  - MEM_ST_IDLE/WAIT/ACCESS/RESP state constants.
  - Default DATA_W/ADDR_W widths shared with the arbiter.
- One natural sub-module: sram_array.
  - Single-port, synchronous-read, write-first RAM.
  - Parameters DATA_W and DEPTH_LOG2; ports clk, we, en, addr, wdata, rdata.
  - Optional $readmemh init file parameter for program loading.

Test Plan:
- Reset: drive reset=0 mid-WAIT → memBusyOut=0, memDataOut=0, memErr=0 immediately. After release, a new request is accepted normally.
- Write then read (WAIT_CYCLES=2):
  - Write 0xDEADBEEF at addr 0x10 → busy high exactly 4 cycles.
  - Read 0x10 → memDataOut=0xDEADBEEF when busy falls.
  - Value holds until the next request.
- WAIT_CYCLES=0: read preloaded word 0x00000013 at addr 0x0 → busy high exactly 2 cycles, data correct.
- Error cases (DEPTH_LOG2=12, BASE_ADDR=0):
  - Read 0x2 (misaligned) → memErr=1, memDataOut=0.
  - Write 0x4000 (out of range) → memErr=1 and no array location modified.
  - Next valid read 0x10 clears memErr.
- memReq pulsed during busy → ignored; only the original access completes and busy length is unchanged.
- Integrated with the arbiter: alternating reqI (addr 0x0) and reqD (write 0x55 to addr 0x20, then read 0x20) → memIReady/memDReady each pulse once, and the arbiter's captured data matches the array contents.
